imem_loader: RTL and testbench

- Writer side of the instruction memory: accepts a byte-stream program image and writes 32-bit instruction words into a DEPTH-entry instruction RAM.
- Holds the CPU in reset while loading.
- Pads every unloaded address with the halt word.
- Releases the CPU only after a verified load.

---
 rtl/imem_loader.sv | 161 ++++++++++++++++
 tb/tb_imem_loader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream instruction memory loader with halt-word padding and CPU reset hold
//
// Purpose: receives a program image (header N, 4*N little-endian data bytes,
// XOR checksum byte), writes 32-bit words into the instruction RAM, fills the
// remaining addresses with HALT_WORD and releases the CPU only after a good load.
//
// Ports:
//   clk, rst_n     clock (rising edge), synchronous active-low reset
//   start          single-cycle load request (accepted in IDLE, DONE, ERR)
//   in_valid/ready byte-stream handshake, in_data carries the byte
//   mem_we/addr/wdata  instruction RAM write port
//   cpu_rst_n      active-low CPU reset, released only in DONE
//   done, err      load result flags
//   words_loaded   word count from the last accepted header
module imem_loader #(
  parameter int          ADDR_W    = 5,
  parameter int          DEPTH     = 2**ADDR_W,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_CHK, S_FILL, S_DONE, S_ERR
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_W  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE_W   = (ADDR_W+1)'(1);

  state_t              r_state;
  state_t              w_next;

  logic                r_in_ready;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic                r_cpu_rst_n;
  logic                r_done;
  logic                r_err;
  logic [ADDR_W:0]     r_words;

  // Word index is one bit wider than the address so N==DEPTH ends cleanly;
  // it also serves as the fill address once data words are written.
  logic [ADDR_W:0]     r_widx;
  logic [1:0]          r_bidx;
  logic [31:0]         r_asm;
  logic [7:0]          r_csum;

  logic                w_xfer;
  logic [31:0]         w_word;
  logic                w_hdr_bad;
  logic                w_word_end;
  logic                w_last_word;

  assign w_xfer      = in_valid & r_in_ready;
  // New byte enters at the top, so after four bytes the first is in [7:0].
  assign w_word      = {in_data, r_asm[31:8]};
  assign w_hdr_bad   = (in_data == 8'd0) || (32'(in_data) > 32'(DEPTH));
  assign w_word_end  = w_xfer && (r_bidx == 2'd3);
  assign w_last_word = (r_widx == (r_words - ONE_W));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (start) w_next = S_HDR;
      S_HDR:  if (w_xfer) w_next = w_hdr_bad ? S_ERR : S_DATA;
      S_DATA: if (w_word_end && w_last_word) w_next = S_CHK;
      S_CHK: begin
        if (w_xfer) begin
          if (in_data != r_csum)     w_next = S_ERR;
          else if (r_words == DEPTH_W) w_next = S_DONE;  // nothing to pad
          else                       w_next = S_FILL;
        end
      end
      S_FILL: if (r_widx == LAST_W) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_rst_n <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_words     <= '0;
      r_widx      <= '0;
      r_bidx      <= '0;
      r_asm       <= '0;
      r_csum      <= '0;
    end else begin
      r_mem_we    <= 1'b0;
      r_in_ready  <= (w_next == S_HDR) || (w_next == S_DATA) || (w_next == S_CHK);
      r_done      <= (w_next == S_DONE);
      r_cpu_rst_n <= (w_next == S_DONE);
      r_err       <= (w_next == S_ERR);
      case (r_state)
        S_HDR: begin
          if (w_xfer && !w_hdr_bad) begin
            r_words <= in_data[ADDR_W:0];
            r_widx  <= '0;
            r_bidx  <= '0;
            r_csum  <= '0;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_asm  <= w_word;
            r_csum <= r_csum ^ in_data;
            r_bidx <= r_bidx + 2'd1;
            if (r_bidx == 2'd3) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_widx[ADDR_W-1:0];
              r_mem_wdata <= w_word;
              r_widx      <= r_widx + ONE_W;
            end
          end
        end
        S_FILL: begin
          r_mem_we    <= 1'b1;
          r_mem_addr  <= r_widx[ADDR_W-1:0];
          r_mem_wdata <= HALT_WORD;
          r_widx      <= r_widx + ONE_W;
        end
        default: ;
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign cpu_rst_n    = r_cpu_rst_n;
  assign done         = r_done;
  assign err          = r_err;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard testbench for imem_loader
module tb_imem_loader;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_rst_n;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .HALT_WORD(HALT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst_n(cpu_rst_n), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
    int                c;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         cyc = 0;
  int         n_pass = 0;
  int         n_total = 0;
  logic [7:0] img[128];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Every write is matched against the scoreboard; data writes also carry the
  // cycle on which they must appear.
  always @(posedge clk) begin
    #1;
    if (mem_we === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_we", 64'(mem_we), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("we_addr", 64'(mem_addr), 64'(mon_e.a));
        check("we_data", 64'(mem_wdata), 64'(mon_e.d));
        if (mon_e.c >= 0) check("we_cycle", 64'(cyc), 64'(mon_e.c));
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit push,
                           input logic [ADDR_W-1:0] a, input logic [31:0] w);
    int n;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("ready_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    if (push) sb.push_back(exp_t'{a, w, cyc + 1});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_stream(input int n, input bit bad, input int maxgap, input int stop_after);
    logic [7:0]  cs;
    logic [31:0] w;
    int          gap;
    cs = 8'h00;
    send_byte(8'(n), 0, 1'b0, '0, '0);
    for (int i = 0; i < 4 * n; i++) begin
      cs  = cs ^ img[i];
      w   = {img[(i/4)*4+3], img[(i/4)*4+2], img[(i/4)*4+1], img[(i/4)*4]};
      gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      send_byte(img[i], gap, (i % 4) == 3, ADDR_W'(i / 4), w);
      if (stop_after == i + 1) return;
    end
    if (!bad)
      for (int a = n; a < DEPTH; a++) sb.push_back(exp_t'{ADDR_W'(a), HALT, -1});
    gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    send_byte(bad ? (cs ^ 8'h01) : cs, gap, 1'b0, '0, '0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done", 64'(done), 64'd1);
    check("cpu_rst_n_done", 64'(cpu_rst_n), 64'd1);
    check("err_clear", 64'(err), 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_words", 64'(words_loaded), 64'd0);
  endtask

  task automatic load_image_a();
    logic [7:0] a [12];
    a = '{8'h13, 8'h05, 8'h20, 8'h00, 8'hef, 8'h00, 8'hc0, 8'h00, 8'h23, 8'h20, 8'ha0, 8'h00};
    for (int i = 0; i < 12; i++) img[i] = a[i];
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    // Three-word image, back-to-back bytes
    load_image_a();
    pulse_start();
    run_stream(3, 1'b0, 0, 0);
    wait_done();
    check("words_loaded_3", 64'(words_loaded), 64'd3);

    // Zero header, then an oversize header
    pulse_start();
    check("done_cleared_by_start", 64'(done), 64'd0);
    check("cpu_rst_after_start", 64'(cpu_rst_n), 64'd0);
    send_byte(8'h00, 0, 1'b0, '0, '0);
    check("err_hdr0", 64'(err), 64'd1);
    check("cpu_rst_n_err", 64'(cpu_rst_n), 64'd0);
    check("in_ready_err", 64'(in_ready), 64'd0);
    pulse_start();
    check("err_cleared", 64'(err), 64'd0);
    check("in_ready_hdr", 64'(in_ready), 64'd1);
    send_byte(8'h21, 0, 1'b0, '0, '0);
    check("err_hdr33", 64'(err), 64'd1);

    // Bad checksum: data writes only
    pulse_start();
    run_stream(3, 1'b1, 0, 0);
    check("err_badchk", 64'(err), 64'd1);
    check("done_badchk", 64'(done), 64'd0);
    repeat (5) @(negedge clk);
    check("sb_empty_badchk", 64'(sb.size()), 64'd0);

    // Full memory: 32 words, no padding, done right after checksum
    for (int i = 0; i < 128; i++) img[i] = 8'($urandom);
    pulse_start();
    run_stream(32, 1'b0, 0, 0);
    check("done_full_immediate", 64'(done), 64'd1);
    check("words_loaded_32", 64'(words_loaded), 64'd32);
    wait_done();

    // Three-word image with random idle gaps
    load_image_a();
    pulse_start();
    run_stream(3, 1'b0, 3, 0);
    wait_done();

    // Reset after the sixth data byte, then a clean reload
    pulse_start();
    run_stream(3, 1'b0, 0, 6);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'd0);
    pulse_start();
    run_stream(3, 1'b0, 0, 0);
    wait_done();
    check("words_loaded_reload", 64'(words_loaded), 64'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
